// File: rtl/bounce_gen_multi.sv
// bounce_gen_multi: multi-channel contact-bounce generator.
//
// Each channel watches a clean input level and, when it changes, emits a
// pseudo-random burst of edges before settling on the new level. Phase
// lengths and bounce counts come from one shared 16-bit Galois LFSR.
// Each channel sees the LFSR rotated by its own index, so channels that
// switch together still bounce differently.
//
// Parameters:
//   NUM_CH            number of channels (1..16)
//   MIN_BOUNCE_CLOCKS minimum phase length in clocks
//   DELAY_BITS        random phase extension width (phase = MIN + 0..2^DELAY_BITS-1)
//   MIN_BOUNCES       minimum edges toward target per transition
//   COUNT_BITS        random bounce extension width
//   LFSR_SEED         LFSR reset value (nonzero)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   en         1: bounce generation, 0: registered pass-through
//   sig_in     clean per-channel input levels
//   bounce_out registered per-channel bouncy outputs
//   busy       per-channel, high while a bounce sequence is in progress
module bounce_gen_multi #(
  parameter int unsigned NUM_CH            = 4,
  parameter int unsigned MIN_BOUNCE_CLOCKS = 1000,
  parameter int unsigned DELAY_BITS        = 12,
  parameter int unsigned MIN_BOUNCES       = 2,
  parameter int unsigned COUNT_BITS        = 2,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] sig_in,
  output logic [NUM_CH-1:0] bounce_out,
  output logic [NUM_CH-1:0] busy
);

  // Widths hold the largest loadable phase length and bounce count.
  localparam int unsigned PhW  = $clog2(MIN_BOUNCE_CLOCKS + 2**DELAY_BITS);
  localparam int unsigned CntW = $clog2(MIN_BOUNCES + 2**COUNT_BITS);

  typedef enum logic [1:0] {StIdle, StAway, StToward} state_e;

  // Shared Galois LFSR, x^16+x^14+x^13+x^11+1, free-running.
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e          state_q, state_d;
    logic            target_q, target_d;
    logic            out_q, out_d;
    logic [PhW-1:0]  phase_q, phase_d, phase_load;
    logic [CntW-1:0] rem_q, rem_d, rem_load;
    logic [31:0]     rot_dbl;
    logic [15:0]     rnd;
    logic            busy_ch;
    logic            unused_rnd;

    // Upper half of the doubled word shifted left by i is rotl(lfsr, i).
    assign rot_dbl    = {lfsr_q, lfsr_q} << i;
    assign rnd        = rot_dbl[31:16];
    assign phase_load = PhW'(MIN_BOUNCE_CLOCKS) + PhW'(rnd[DELAY_BITS-1:0]);
    assign rem_load   = CntW'(MIN_BOUNCES) + CntW'(rnd[15 -: COUNT_BITS]);
    assign unused_rnd = ^{rot_dbl[15:0], rnd};

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= StIdle;
        target_q <= 1'b0;
        out_q    <= sig_in[i];
        phase_q  <= '0;
        rem_q    <= '0;
      end else begin
        state_q  <= state_d;
        target_q <= target_d;
        out_q    <= out_d;
        phase_q  <= phase_d;
        rem_q    <= rem_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      target_d = target_q;
      out_d    = out_q;
      phase_d  = phase_q;
      rem_d    = rem_q;
      if (!en) begin
        state_d = StIdle;
        out_d   = sig_in[i];
      end else begin
        case (state_q)
          StIdle: begin
            if (sig_in[i] != out_q) begin
              target_d = sig_in[i];
              rem_d    = rem_load;
              phase_d  = phase_load;
              state_d  = StAway;
            end
          end
          StAway: begin
            // Abort wins over a coincident phase expiry.
            if (sig_in[i] != target_q) begin
              out_d   = sig_in[i];
              state_d = StIdle;
            end else if (phase_q == PhW'(1)) begin
              out_d = target_q;
              rem_d = rem_q - CntW'(1);
              if (rem_q == CntW'(1)) begin
                state_d = StIdle;
              end else begin
                phase_d = phase_load;
                state_d = StToward;
              end
            end else begin
              phase_d = phase_q - PhW'(1);
            end
          end
          StToward: begin
            if (sig_in[i] != target_q) begin
              out_d   = sig_in[i];
              state_d = StIdle;
            end else if (phase_q == PhW'(1)) begin
              out_d   = ~target_q;
              phase_d = phase_load;
              state_d = StAway;
            end else begin
              phase_d = phase_q - PhW'(1);
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end

    always_comb begin
      busy_ch = (state_q != StIdle);
    end

    assign busy[i]       = busy_ch;
    assign bounce_out[i] = out_q;
  end

endmodule

// File: tb/tb_bounce_gen_multi.sv
// Directed bench for bounce_gen_multi with a cycle-accurate reference model.
module tb_bounce_gen_multi;

  localparam logic [15:0] Seed = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] sig_in;
  logic [3:0] bounce_out;
  logic [3:0] busy;

  bounce_gen_multi #(
    .NUM_CH           (4),
    .MIN_BOUNCE_CLOCKS(8),
    .DELAY_BITS       (3),
    .MIN_BOUNCES      (2),
    .COUNT_BITS       (2),
    .LFSR_SEED        (Seed)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .bounce_out(bounce_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model: mode 0 idle, 1 away, 2 toward.
  int         m_mode[4];
  logic       m_tgt[4];
  int         m_left[4];
  int         m_rem[4];
  int         m_n[4];
  logic [3:0] m_out;
  logic [3:0] m_busy;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int s);
    rotl16 = (s == 0) ? x : ((x << s) | (x >> (16 - s)));
  endfunction

  task automatic model_step();
    logic [15:0] r;
    int d;
    int n;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_mode[i] = 0;
        m_left[i] = 0;
        m_rem[i]  = 0;
      end
      m_out  = sig_in;
      m_lfsr = Seed;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r = rotl16(m_lfsr, i);
        d = 8 + int'(r[2:0]);
        n = 2 + int'(r[15:14]);
        if (!en) begin
          m_mode[i] = 0;
          m_out[i]  = sig_in[i];
        end else if (m_mode[i] == 0) begin
          if (sig_in[i] != m_out[i]) begin
            m_tgt[i]  = sig_in[i];
            m_rem[i]  = n;
            m_n[i]    = n;
            m_left[i] = d;
            m_mode[i] = 1;
          end
        end else if (sig_in[i] != m_tgt[i]) begin
          m_out[i]  = sig_in[i];
          m_mode[i] = 0;
        end else if (m_left[i] > 1) begin
          m_left[i] = m_left[i] - 1;
        end else if (m_mode[i] == 1) begin
          m_out[i] = m_tgt[i];
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) begin
            m_mode[i] = 0;
          end else begin
            m_left[i] = d;
            m_mode[i] = 2;
          end
        end else begin
          m_out[i]  = ~m_tgt[i];
          m_left[i] = d;
          m_mode[i] = 1;
        end
      end
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
    for (int i = 0; i < 4; i++) m_busy[i] = (m_mode[i] != 0);
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare the DUT against it shortly after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check4("model_out", bounce_out, m_out);
    check4("model_busy", busy, m_busy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       prev0;
    logic [3:0] prev;
    int         rises;
    int         rises4[4];
    int         last_edge;
    int         last_rise;
    int         t0;
    int         bad_iv;
    bit         first_ok;
    bit         done;
    bit         found;

    // Reset held for three edges.
    rst    = 1'b1;
    en     = 1'b1;
    sig_in = 4'b1010;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check4("reset_out", bounce_out, 4'b1010);
    check4("reset_busy", busy, 4'b0000);

    // Single bounce on channel 0.
    sig_in    = 4'b1011;
    t0        = cyc;
    prev0     = bounce_out[0];
    rises     = 0;
    last_edge = -1;
    last_rise = -1;
    bad_iv    = 0;
    first_ok  = 1'b0;
    done      = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      if (bounce_out[0] !== prev0) begin
        if (last_edge < 0) begin
          first_ok = (cyc - t0 >= 9) && (cyc - t0 <= 16);
        end else if ((cyc - last_edge < 8) || (cyc - last_edge > 15)) begin
          bad_iv++;
        end
        last_edge = cyc;
        if (bounce_out[0] === 1'b1) begin
          rises++;
          last_rise = cyc;
        end
      end
      prev0 = bounce_out[0];
      if (busy[0] === 1'b0) done = 1'b1;
    end
    check1("single_done", done, 1'b1);
    check1("single_rise_range", (rises >= 2) && (rises <= 5), 1'b1);
    check_int("single_rises_model", rises, m_n[0]);
    check_int("single_bad_intervals", bad_iv, 0);
    check1("single_first_edge", first_ok, 1'b1);
    check1("single_final", bounce_out[0], 1'b1);
    check_int("single_busy_fall", last_rise, cyc);

    // Pass-through with en low.
    en     = 1'b0;
    sig_in = 4'b0000;
    tick();
    check4("pt_0000", bounce_out, 4'b0000);
    check4("pt_busy0", busy, 4'b0000);
    sig_in = 4'b1111;
    #1;
    check4("pt_delay1", bounce_out, 4'b0000);
    tick();
    check4("pt_1111", bounce_out, 4'b1111);
    check4("pt_busy1", busy, 4'b0000);
    sig_in = 4'b0101;
    #1;
    check4("pt_delay2", bounce_out, 4'b1111);
    tick();
    check4("pt_0101", bounce_out, 4'b0101);
    check4("pt_busy2", busy, 4'b0000);

    // Abort on channel 1 after three cycles.
    en = 1'b1;
    tick();
    sig_in = 4'b0111;
    repeat (3) begin
      tick();
      check1("abort_hold_out", bounce_out[1], 1'b0);
      check1("abort_busy_high", busy[1], 1'b1);
    end
    sig_in = 4'b0101;
    tick();
    check1("abort_out", bounce_out[1], 1'b0);
    check1("abort_busy", busy[1], 1'b0);
    repeat (20) begin
      tick();
      check1("abort_no_edge", bounce_out[1], 1'b0);
    end

    // Reset in the middle of a channel 2 TOWARD phase.
    en     = 1'b0;
    sig_in = 4'b0001;
    tick();
    en = 1'b1;
    tick();
    sig_in = 4'b0101;
    found  = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (m_mode[2] == 2) found = 1'b1;
    end
    check1("mid_found_toward", found, 1'b1);
    check1("mid_busy_before", busy[2], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("mid_out", bounce_out[2], 1'b1);
    check1("mid_busy", busy[2], 1'b0);
    check4("mid_all_out", bounce_out, 4'b0101);

    // Concurrent transitions on all channels, from a fresh LFSR.
    en     = 1'b0;
    sig_in = 4'b0000;
    tick();
    en = 1'b1;
    tick();
    sig_in = 4'b1111;
    prev   = bounce_out;
    for (int i = 0; i < 4; i++) rises4[i] = 0;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (prev[i] === 1'b0 && bounce_out[i] === 1'b1) rises4[i]++;
      end
      prev = bounce_out;
      if (busy === 4'b0000) done = 1'b1;
    end
    check1("conc_done", done, 1'b1);
    check4("conc_final", bounce_out, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      check_int($sformatf("conc_rises_ch%0d", i), rises4[i], m_n[i]);
      check1($sformatf("conc_range_ch%0d", i), (rises4[i] >= 2) && (rises4[i] <= 5), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
